wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL take parameter AGE_LIMIT, default 3, range 1..7: cycles port B may wait before it overrides port A.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port a_valid  input  1  port A (ALU) result valid.
REQ-005 SHALL have port a_ready  output  1  port A can accept.
REQ-006 SHALL have ports a_dest  input  4  and a_data  input  28: destination register index and result.
REQ-007 SHALL have ports b_valid  input  1, b_ready  output  1, b_dest  input  4 and b_data  input  28: the port B (MUL/LSU) equivalents.
REQ-008 SHALL have port wen  output  1  register file write enable, registered.
REQ-009 SHALL have port dest_sel  output  4  register file write index, registered.
REQ-010 SHALL have port data_out  output  28  register file write data, registered.
REQ-011 SHALL have port busy  output  1  high when either holding slot is occupied or wen=1.

Function
REQ-012 SHALL accept port X when X_valid & X_ready at a posedge; X_dest and X_data are captured into X's one-entry holding slot.
REQ-013 SHALL drop an accepted entry with X_dest=0 at capture; its slot stays empty and no write is ever issued.
REQ-014 SHALL drive X_ready = slot X empty OR slot X granted in the current cycle, so back-to-back acceptance runs at one entry per cycle per port.
REQ-015 SHALL grant each cycle at most one occupied slot: A if occupied and b_age < AGE_LIMIT, otherwise B if occupied.
REQ-016 SHALL keep b_age (3 bits): +1 per cycle B is occupied and not granted, saturating at 7, cleared to 0 on B grant or when slot B is empty.
REQ-017 SHALL load the granted slot into wen=1/dest_sel/data_out at the next posedge and empty that slot; with no grant, wen=0 and dest_sel/data_out hold their last values.
REQ-018 SHALL produce wen exactly one cycle after capture when uncontended (handshake edge N, wen high from edge N+1 until edge N+2).
REQ-019 SHALL preserve per-port order; when A and B target the same index in the same cycle, A writes first and B's value is final.
REQ-020 SHALL write each accepted nonzero-dest entry exactly once; no loss or duplication under any valid/ready pattern.
REQ-021 SHALL make dest_sel change only while wen is valid, because the downstream register file samples on negedge of clk within the same cycle.

Reset
REQ-022 SHALL, on rst high, immediately clear both slots, b_age, wen, dest_sel and data_out to 0; a_ready=b_ready=1 and busy=0 while rst is high.
REQ-023 SHALL discard in-flight entries when reset is asserted mid-operation; no write is issued after rst deasserts until a new handshake occurs.

Configuration
REQ-024 SHALL, with WB_FWD_EN defined, add ports q_rs input 4, q_hit output 1 and q_data output 28, where q_hit = wen & (dest_sel==q_rs) & (q_rs!=0) combinationally and q_data = data_out.
REQ-025 SHALL, without WB_FWD_EN, omit q_rs/q_hit/q_data entirely, with all other behaviour unchanged.

Structure
REQ-026 SHALL take REG_W=28, REG_IDX_W=4 and NUM_REGS=16 from the shared thread package, shared with the register file.
REQ-027 SHALL implement each holding slot as one sub-module, wb_slot (valid/ready skid entry with zero-dest drop), instantiated twice.

Verification
REQ-028 SHALL cover A alone: a_valid, a_dest=5, a_data=0x0000123 at edge 0 -> wen=1, dest_sel=5, data_out=0x0000123 after edge 1, wen=0 after edge 2.
REQ-029 SHALL cover simultaneous writes: A(dest 3, 0xAAAAAAA) and B(dest 3, 0x5555555) at the same edge -> A written in cycle 1, B in cycle 2, final r3 = 0x5555555.
REQ-030 SHALL cover B starvation: A valid every cycle, B held with AGE_LIMIT=3 -> B granted on the 4th arbitration cycle, then b_age=0 and A resumes.
REQ-031 SHALL cover zero-dest drop: a_dest=0 with data 0xFFFFFFF accepted -> wen never asserts and busy stays 0.
REQ-032 SHALL cover reset mid-op: both slots full, rst pulsed asynchronously -> wen=0 immediately, no write after release, a_ready=b_ready=1.
REQ-033 SHALL cover forwarding (WB_FWD_EN): wen=1, dest_sel=7, q_rs=7 -> q_hit=1 with q_data=data_out; q_rs=0 -> q_hit=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared thread package: register file geometry and writeback entry types.
package wb_arbiter_pkg;
  localparam int REG_W     = 28;
  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 16;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic [REG_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } gnt_e;
endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot; entries aimed at r0 are dropped at capture.
module wb_slot
  import wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [REG_IDX_W-1:0] dest_i,
  input  logic [REG_W-1:0]     data_i,
  input  logic                 grant_i,
  output logic                 ready_o,
  output logic                 occ_o,
  output logic [REG_IDX_W-1:0] dest_o,
  output logic [REG_W-1:0]     data_o
);
  logic      occ_q, occ_d;
  wb_entry_t ent_q, ent_d;

  // Draining this cycle frees the slot for the incoming entry.
  assign ready_o = ~occ_q | grant_i;

  always_comb begin
    occ_d = occ_q;
    ent_d = ent_q;
    if (grant_i) occ_d = 1'b0;
    if (valid_i && ready_o && (dest_i != '0)) begin
      occ_d = 1'b1;
      ent_d = '{dest: dest_i, data: data_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= 1'b0;
      ent_q <= '0;
    end else begin
      occ_q <= occ_d;
      ent_q <= ent_d;
    end
  end

  assign occ_o  = occ_q;
  assign dest_o = ent_q.dest;
  assign data_o = ent_q.data;
endmodule

// File: rtl/wb_arbiter.sv
// Two-port register file writeback arbiter, A preferred with B aging override.
// Optional forwarding port enabled by WB_FWD_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int AGE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [REG_IDX_W-1:0] a_dest,
  input  logic [REG_W-1:0]     a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [REG_IDX_W-1:0] b_dest,
  input  logic [REG_W-1:0]     b_data,
  output logic                 wen,
  output logic [REG_IDX_W-1:0] dest_sel,
  output logic [REG_W-1:0]     data_out,
  output logic                 busy
`ifdef WB_FWD_EN
  ,
  input  logic [REG_IDX_W-1:0] q_rs,
  output logic                 q_hit,
  output logic [REG_W-1:0]     q_data
`endif
);
  logic                 a_occ, b_occ;
  logic [REG_IDX_W-1:0] a_sdest, b_sdest;
  logic [REG_W-1:0]     a_sdata, b_sdata;
  gnt_e                 gnt;
  logic [2:0]           b_age_q, b_age_d;
  logic                 wen_q, wen_d;
  logic [REG_IDX_W-1:0] dest_q, dest_d;
  logic [REG_W-1:0]     data_q, data_d;

  wb_slot u_slot_a (
    .clk(clk), .rst(rst), .valid_i(a_valid), .dest_i(a_dest), .data_i(a_data),
    .grant_i(gnt == GNT_A), .ready_o(a_ready), .occ_o(a_occ),
    .dest_o(a_sdest), .data_o(a_sdata)
  );

  wb_slot u_slot_b (
    .clk(clk), .rst(rst), .valid_i(b_valid), .dest_i(b_dest), .data_i(b_data),
    .grant_i(gnt == GNT_B), .ready_o(b_ready), .occ_o(b_occ),
    .dest_o(b_sdest), .data_o(b_sdata)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (a_occ && (b_age_q < 3'(AGE_LIMIT))) gnt = GNT_A;
    else if (b_occ)                         gnt = GNT_B;
  end

  // dest_sel/data_out only move on a write, keeping them stable for the
  // register file's negedge sample.
  always_comb begin
    b_age_d = b_age_q;
    wen_d   = 1'b0;
    dest_d  = dest_q;
    data_d  = data_q;
    if (!b_occ || gnt == GNT_B) b_age_d = '0;
    else if (b_age_q != 3'd7)   b_age_d = b_age_q + 3'd1;
    if (gnt == GNT_A) begin
      wen_d  = 1'b1;
      dest_d = a_sdest;
      data_d = a_sdata;
    end else if (gnt == GNT_B) begin
      wen_d  = 1'b1;
      dest_d = b_sdest;
      data_d = b_sdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_age_q <= '0;
      wen_q   <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
    end else begin
      b_age_q <= b_age_d;
      wen_q   <= wen_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  assign wen      = wen_q;
  assign dest_sel = dest_q;
  assign data_out = data_q;
  assign busy     = a_occ | b_occ | wen_q;

`ifdef WB_FWD_EN
  assign q_hit  = wen_q & (dest_q == q_rs) & (q_rs != '0);
  assign q_data = data_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: per-port expected-write queues plus timed checks.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_dest, b_dest;
  logic [27:0] a_data, b_data;
  logic        wen, busy;
  logic [3:0]  dest_sel;
  logic [27:0] data_out;
`ifdef WB_FWD_EN
  logic [3:0]  q_rs;
  logic        q_hit;
  logic [27:0] q_data;
`endif

  wb_arbiter #(.AGE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .wen(wen), .dest_sel(dest_sel), .data_out(data_out), .busy(busy)
`ifdef WB_FWD_EN
    , .q_rs(q_rs), .q_hit(q_hit), .q_data(q_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_b_cyc = -1;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Each write must be the oldest outstanding entry of one of the two ports.
  always @(negedge clk) begin
    if (!rst && wen === 1'b1) begin
      if (qa.size() > 0 && qa[0] == {dest_sel, data_out}) begin
        chk("wr_a", 36'({dest_sel, data_out}), 36'(qa.pop_front()));
      end else if (qb.size() > 0) begin
        chk("wr_b", 36'({dest_sel, data_out}), 36'(qb.pop_front()));
        last_b_cyc = cyc;
      end else begin
        chk("wr_spur", 36'({dest_sel, data_out}), 36'hF_FFFF_FFFF);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic ar, br;
  int   start;

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0;
    a_dest = 0; b_dest = 0; a_data = 0; b_data = 0;
`ifdef WB_FWD_EN
    q_rs = 0;
`endif
    step(); step();
    chk("rst_wen", 36'(wen), 36'd0);
    chk("rst_ardy", 36'(a_ready), 36'd1);
    chk("rst_brdy", 36'(b_ready), 36'd1);
    chk("rst_busy", 36'(busy), 36'd0);
    chk("rst_dest", 36'(dest_sel), 36'd0);
    chk("rst_data", 36'(data_out), 36'd0);
    rst = 1'b0;
    step();

    // A alone
    a_valid = 1; a_dest = 4'd5; a_data = 28'h0000123;
    qa.push_back({4'd5, 28'h0000123});
    step();
    a_valid = 0;
    @(negedge clk);
    chk("a_lat0", 36'(wen), 36'd0);
    step();
    @(negedge clk);
    chk("a_wen", 36'(wen), 36'd1);
    chk("a_dest", 36'(dest_sel), 36'd5);
    chk("a_data", 36'(data_out), 36'h0000123);
`ifdef WB_FWD_EN
    q_rs = 4'd5; #1;
    chk("fwd_hit", 36'(q_hit), 36'd1);
    chk("fwd_data", 36'(q_data), 36'h0000123);
    q_rs = 4'd0; #1;
    chk("fwd_r0", 36'(q_hit), 36'd0);
`endif
    step();
    @(negedge clk);
    chk("a_wen_off", 36'(wen), 36'd0);
    chk("a_dest_hold", 36'(dest_sel), 36'd5);
    step();

    // Simultaneous same-index writes
    a_valid = 1; a_dest = 4'd3; a_data = 28'hAAAAAAA;
    b_valid = 1; b_dest = 4'd3; b_data = 28'h5555555;
    qa.push_back({4'd3, 28'hAAAAAAA});
    qb.push_back({4'd3, 28'h5555555});
    step();
    a_valid = 0; b_valid = 0;
    step();
    @(negedge clk);
    chk("sim_1st", 36'({wen, data_out}), {7'd0, 1'b1, 28'hAAAAAAA});
    step();
    @(negedge clk);
    chk("sim_2nd", 36'({wen, data_out}), {7'd0, 1'b1, 28'h5555555});
    step();
    @(negedge clk);
    chk("sim_final", 36'({wen, dest_sel, data_out}), {3'd0, 1'b0, 4'd3, 28'h5555555});
    step();

    // B starvation under continuous A traffic
    a_valid = 1; a_dest = 4'd1; a_data = 28'h0000100;
    b_valid = 1; b_dest = 4'd2; b_data = 28'h8000002;
    start = cyc;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cyc == start + 6)
        chk("a_resume", 36'({wen, data_out[27]}), 36'b10);
      ar = a_ready; br = b_ready;
      @(posedge clk);
      if (a_valid && ar) qa.push_back({a_dest, a_data});
      if (b_valid && br) qb.push_back({b_dest, b_data});
      #1;
      if (a_valid && ar) a_data = a_data + 28'd1;
      if (b_valid && br) b_valid = 0;
    end
    a_valid = 0;
    repeat (4) step();
    chk("starve_cyc", 36'(last_b_cyc - start), 36'd5);

    // Zero-dest drop
    a_valid = 1; a_dest = 4'd0; a_data = 28'hFFFFFFF;
    step();
    a_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("zd_wen", 36'(wen), 36'd0);
      chk("zd_busy", 36'(busy), 36'd0);
      step();
    end

    // Reset mid-operation with both slots full and a write in flight
    a_valid = 1; a_dest = 4'd4; a_data = 28'h0000044;
    b_valid = 1; b_dest = 4'd6; b_data = 28'h8000066;
    qa.push_back({4'd4, 28'h0000044});
    qb.push_back({4'd6, 28'h8000066});
    step();
    b_valid = 0; a_data = 28'h0000045;
    qa.push_back({4'd4, 28'h0000045});
    step();
    a_valid = 0;
    @(negedge clk);
    chk("pre_rst_busy", 36'(busy), 36'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wen", 36'(wen), 36'd0);
    chk("mid_rst_ardy", 36'(a_ready), 36'd1);
    chk("mid_rst_brdy", 36'(b_ready), 36'd1);
    chk("mid_rst_busy", 36'(busy), 36'd0);
    qa.delete();
    qb.delete();
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_wen", 36'(wen), 36'd0);
      step();
    end

    // Random traffic on both ports
    for (int i = 0; i < 300; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_dest  = 4'($urandom_range(0, 15));
      a_data  = {1'b0, 27'($urandom)};
      b_valid = 1'($urandom_range(0, 1));
      b_dest  = 4'($urandom_range(0, 15));
      b_data  = {1'b1, 27'($urandom)};
      @(negedge clk);
      ar = a_ready; br = b_ready;
      @(posedge clk);
      if (a_valid && ar && a_dest != 0) qa.push_back({a_dest, a_data});
      if (b_valid && br && b_dest != 0) qb.push_back({b_dest, b_data});
      #1;
    end
    a_valid = 0; b_valid = 0;
    repeat (8) step();
    chk("drain_a", 36'(qa.size()), 36'd0);
    chk("drain_b", 36'(qb.size()), 36'd0);
    chk("idle_busy", 36'(busy), 36'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
